// File: rtl/ad9220_pkg.sv
// ----------------------------------------------------------------------------
// ad9220_pkg
// Shared definitions for the AD9220 capture controller:
//   - state_t   : controller FSM states
//   - ADC_W     : ADC sample width (12 bits)
//   - HDR_BYTE  : frame header byte sent ahead of the sample payload
// ----------------------------------------------------------------------------
package ad9220_pkg;

    localparam int          ADC_W    = 12;
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_HDR     = 3'd3,
        S_SEND_HI = 3'd4,
        S_SEND_LO = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/ad9220_sbuf.sv
// ----------------------------------------------------------------------------
// ad9220_sbuf
// DEPTH x ADC_W simple dual-port sample buffer, one write port and one
// registered read port. Contents are not reset.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, data appears on o_rdata one cycle later
//   o_rdata  : registered read data
// ----------------------------------------------------------------------------
module ad9220_sbuf
    import ad9220_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [ADC_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [ADC_W-1:0] o_rdata
);

    logic [ADC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ad9220_capture_ctrl.sv
// ----------------------------------------------------------------------------
// ad9220_capture_ctrl
// Captures DEPTH decimated AD9220 samples into a buffer, then streams them to
// a UART transmitter as: A5, then {0,word[11:8]}, word[7:0] per word.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : capture request (honoured in IDLE only)
//   decim         : keep one sample per decim+1 strobes, latched at start
//   adc_vld/db    : ADC strobe and data
//   ad9220_start  : ADC gate enable, high during FLUSH and CAPTURE
//   tx_data/valid : byte stream to transmitter, tx_ready accepts
//   busy          : high outside IDLE
//   done          : one-cycle pulse after the last byte is accepted
// ----------------------------------------------------------------------------
module ad9220_capture_ctrl
    import ad9220_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       decim,
    input  logic             adc_vld,
    input  logic [ADC_W-1:0] adc_db,
    output logic             ad9220_start,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    state_t           r_state, w_next;
    logic             r_armed;
    logic [7:0]       r_decim;
    logic [7:0]       r_dec_cnt;
    logic [FW-1:0]    r_flush_cnt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_full;
    logic             w_start_ok;
    logic             w_we;
    logic             w_last_wr;
    logic             w_flush_end;
    logic [AW-1:0]    w_raddr;
    logic [ADC_W-1:0] w_rdata;

    // r_armed is clear in the first edge after reset release, so a start
    // present while rst_n rises is not taken.
    assign w_start_ok  = start && r_armed;
    assign w_we        = (r_state == S_CAPTURE) && adc_vld && (r_dec_cnt == 8'd0) && !r_full;
    assign w_last_wr   = w_we && (r_wr_ptr == AW'(DEPTH - 1));
    assign w_flush_end = (PIPE_LAT == 0) || (adc_vld && (r_flush_cnt == FW'(PIPE_LAT - 1)));

    ad9220_sbuf #(.DEPTH(DEPTH), .AW(AW)) u_sbuf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (adc_db),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read address looks one word ahead on SEND_LO acceptance so the
    // registered RAM output already holds the next word when SEND_HI starts.
    // HDR covers the latency of the very first read.
    always_comb begin
        w_next       = r_state;
        ad9220_start = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        w_raddr      = r_rd_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                ad9220_start = 1'b1;
                if (w_flush_end) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                ad9220_start = 1'b1;
                if (w_last_wr) w_next = S_HDR;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) w_next = S_SEND_HI;
            end
            S_SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = {4'h0, w_rdata[ADC_W-1:8]};
                if (tx_ready) w_next = S_SEND_LO;
            end
            S_SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = w_rdata[7:0];
                if (tx_ready) begin
                    w_raddr = r_rd_ptr + AW'(1);
                    w_next  = (r_rd_ptr == AW'(DEPTH - 1)) ? S_DONE : S_SEND_HI;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_decim     <= 8'd0;
            r_dec_cnt   <= 8'd0;
            r_flush_cnt <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_full      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_decim     <= decim;
                        r_dec_cnt   <= 8'd0;
                        r_flush_cnt <= '0;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_full      <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (adc_vld) r_flush_cnt <= r_flush_cnt + FW'(1);
                end
                S_CAPTURE: begin
                    if (adc_vld && !r_full) begin
                        r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
                    end
                    if (w_we) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (w_last_wr) r_full <= 1'b1;
                    end
                end
                S_SEND_LO: begin
                    if (tx_ready) r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9220_capture_ctrl.sv
module tb_ad9220_capture_ctrl;

    localparam int DEPTH    = 4;
    localparam int PIPE_LAT = 3;
    localparam int NBYTES   = 1 + 2 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  decim = 8'd0;
    logic        adc_vld = 1'b0;
    logic [11:0] adc_db = 12'd0;
    logic        ad9220_start;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int bytes_seen = 0;
    int done_seen  = 0;
    logic [7:0] exp_q[$];
    logic       mon_prev_stall;
    logic [7:0] mon_prev_data;
    logic [7:0] mon_exp;

    ad9220_capture_ctrl #(.DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decim        (decim),
        .adc_vld      (adc_vld),
        .adc_db       (adc_db),
        .ad9220_start (ad9220_start),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected byte per accepted transfer.
    initial begin
        mon_prev_stall = 1'b0;
        mon_prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_stall = 1'b0;
            end else begin
                if (mon_prev_stall) begin
                    chk("stall_valid_held", int'(tx_valid), 1);
                    chk("stall_data_stable", int'(tx_data), int'(mon_prev_data));
                end
                if (tx_valid) chk("gate_off_while_tx", int'(ad9220_start), 0);
                if (tx_valid && tx_ready) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got 0x%0h expected no byte", tx_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("tx_byte", int'(tx_data), int'(mon_exp));
                    end
                end
                if (done) begin
                    done_seen++;
                    chk("done_after_last_byte", exp_q.size(), 0);
                end
                mon_prev_stall = tx_valid && !tx_ready;
                mon_prev_data  = tx_data;
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, int'(tx_valid), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_ad9220_start"}, int'(ad9220_start), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Releases reset with start already high: that start must be ignored.
    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("no_start_at_reset_release", int'(busy), 0);
    endtask

    // One full capture/transmit frame. The reference model: drop the first
    // PIPE_LAT strobes after the start cycle, then keep strobe indices
    // PIPE_LAT + k*(decim+1) for k = 0..DEPTH-1.
    task automatic run_frame(input int dcm, input int vld_pct, input int rdy_pct,
                             input bit ramp, input bit noise, input bit coinc,
                             input bit chk_bubble);
        int strobes[$];
        int need, ramp_v, cyc, first_tx, done_cyc, b0, d0;
        bit pushed, seen_done;
        logic [11:0] w;
        need = PIPE_LAT + (DEPTH - 1) * (dcm + 1) + 1;
        ramp_v = 1;
        b0 = bytes_seen;
        d0 = done_seen;
        @(posedge clk); #1;
        start    = 1'b1;
        decim    = dcm[7:0];
        adc_vld  = coinc;
        adc_db   = 12'hFFF;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("gate_after_start", int'(ad9220_start), 1);
        pushed = 1'b0;
        seen_done = 1'b0;
        cyc = 0;
        first_tx = -1;
        done_cyc = -1;
        while (!seen_done && cyc < 20000) begin
            if (tx_valid && first_tx < 0) first_tx = cyc;
            if (done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
            adc_vld = (($urandom % 100) < vld_pct);
            adc_db  = ramp ? ramp_v[11:0] : 12'($urandom);
            if (adc_vld) begin
                if (!pushed) strobes.push_back(int'(adc_db));
                ramp_v++;
            end
            tx_ready = (($urandom % 100) < rdy_pct);
            start = noise && (done || (busy && ($urandom % 6 == 0)));
            if (!pushed && strobes.size() == need) begin
                exp_q.push_back(8'hA5);
                for (int k = 0; k < DEPTH; k++) begin
                    w = 12'(strobes[PIPE_LAT + k * (dcm + 1)]);
                    exp_q.push_back({4'h0, w[11:8]});
                    exp_q.push_back(w[7:0]);
                end
                pushed = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start   = 1'b0;
        adc_vld = 1'b0;
        if (!seen_done) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got no done after %0d cycles, expected done", cyc);
        end
        chk("frame_byte_count", bytes_seen - b0, NBYTES);
        chk("frame_done_pulses", done_seen - d0, 1);
        chk("frame_queue_drained", exp_q.size(), 0);
        chk("idle_after_done", int'(busy), 0);
        if (chk_bubble) chk("no_bubbles", done_cyc - first_tx, NBYTES);
        exp_q.delete();
    endtask

    // Start a frame, accept only the header, then reset while in SEND_HI.
    task automatic abort_in_send_hi();
        int n, rv;
        @(posedge clk); #1;
        exp_q.push_back(8'hA5);
        start    = 1'b1;
        decim    = 8'd0;
        adc_vld  = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        rv = 1;
        while (!tx_valid && n < 200) begin
            adc_vld = 1'b1;
            adc_db  = rv[11:0];
            rv++;
            @(posedge clk); #1;
            n++;
        end
        adc_vld = 1'b0;
        if (!tx_valid) begin
            total++;
            bad++;
            $display("FAIL abort_hdr_timeout: got tx_valid=0 expected 1");
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        chk("abort_send_hi_valid", int'(tx_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_outputs_zero("abort_async");
        exp_q.delete();
        @(posedge clk); #1;
        chk_outputs_zero("abort_edge");
        release_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        release_reset();

        // Ramp, decim=0, ready held high.
        run_frame(0, 100, 100, 1'b1, 1'b0, 1'b0, 1'b1);
        // Ramp with decimation by 3.
        run_frame(2, 100, 100, 1'b1, 1'b0, 1'b0, 1'b1);
        // Strobe coincident with start must not count as a flush strobe.
        run_frame(0, 100, 100, 1'b1, 1'b0, 1'b1, 1'b0);
        // Random data, gaps and transmitter stalls.
        run_frame(0, 60, 40, 1'b0, 1'b0, 1'b0, 1'b0);
        // Spurious start pulses while busy, including during DONE.
        run_frame(3, 70, 50, 1'b0, 1'b1, 1'b0, 1'b0);
        // Reset mid-transmit, then a clean frame.
        abort_in_send_hi();
        run_frame(1, 80, 60, 1'b1, 1'b0, 1'b0, 1'b0);
        // Maximum decimation.
        run_frame(255, 80, 70, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_frame(int'($urandom % 6), 50 + int'($urandom % 50), 30 + int'($urandom % 70),
                      1'b0, 1'b1, bit'($urandom % 2), 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ad9220_capture_ctrl.md
AD9220_CAPTURE_CTRL -- requirements
Module: ad9220_capture_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: sample buffer depth in 12-bit words, power of two.
REQ-002 SHALL have parameter PIPE_LAT, default 3: ADC pipeline-latency strobes discarded after enable.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle capture request.
REQ-006 SHALL have port decim, input, 8: keep one sample per (decim+1) strobes; sampled at accepted start.
REQ-007 SHALL have port adc_vld, input, 1: one-cycle strobe per new ADC word, synchronous to clk.
REQ-008 SHALL have port adc_db, input, 12: ADC data, valid when adc_vld=1.
REQ-009 SHALL have port ad9220_start, output, 1: ADC gate enable, high in FLUSH and CAPTURE only.
REQ-010 SHALL have port tx_data, output, 8: byte to UART transmitter.
REQ-011 SHALL have port tx_valid, output, 1: tx_data valid.
REQ-012 SHALL have port tx_ready, input, 1: transmitter accepts byte when tx_valid and tx_ready both high.
REQ-013 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse after last byte accepted.

Function
REQ-015 SHALL implement states IDLE, FLUSH, CAPTURE, HDR, SEND_HI, SEND_LO, DONE.
REQ-016 IDLE -> FLUSH on start=1; decim latched, flush counter, decimation counter and write pointer cleared in the same cycle.
REQ-017 FLUSH SHALL count adc_vld strobes; after PIPE_LAT strobes -> CAPTURE; those strobes are never stored.
REQ-018 CAPTURE SHALL write adc_db when adc_vld=1 and decimation counter=0; counter counts 0..decim, wraps to 0.
REQ-019 decim=0 SHALL store every strobe; decim=255 SHALL store one in 256.
REQ-020 After DEPTH-th write -> HDR next cycle; ad9220_start deasserts in that same cycle; further adc_vld ignored.
REQ-021 HDR SHALL present tx_data=8'hA5, tx_valid=1; on acceptance -> SEND_HI.
REQ-022 SEND_HI SHALL present {4'h0, word[11:8]}; SEND_LO SHALL present word[7:0]; read pointer increments on SEND_LO acceptance.
REQ-023 After SEND_LO acceptance of word DEPTH-1 -> DONE; otherwise -> SEND_HI.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable; tx_valid SHALL not drop before acceptance.
REQ-025 Byte order SHALL be A5 then HI/LO per word in write order; total bytes = 1 + 2*DEPTH.
REQ-026 DONE SHALL assert done for exactly one cycle -> IDLE.
REQ-027 start outside IDLE SHALL be ignored, including start coincident with DONE.
REQ-028 adc_vld coincident with start in IDLE SHALL not count as a flush strobe.
REQ-029 Buffer read latency SHALL be hidden: first tx_valid in HDR, no bubbles between accepted bytes when tx_ready held high.
REQ-030 Write/read pointers SHALL be log2(DEPTH) bits plus full flag; no wrap overwrite possible.

Reset
REQ-031 rst_n low SHALL force IDLE, tx_valid=0, tx_data=0, ad9220_start=0, busy=0, done=0, all counters/pointers 0, at any state including mid-capture and mid-transmit.
REQ-032 Buffer contents need not be reset; after reset no stale data SHALL be transmitted.
REQ-033 Reset deassertion SHALL take effect on next rising edge; no start accepted in the cycle rst_n rises.

Structure
REQ-034 Shared package ad9220_pkg SHALL hold state enum, header constant 8'hA5, ADC data width 12.
REQ-035 Single sub-module ad9220_sbuf SHALL implement the DEPTH x 12 simple dual-port RAM with registered read.
REQ-036 Controller FSM, counters and byte mux SHALL reside in ad9220_capture_ctrl.

Verification
REQ-037 DEPTH=4, decim=0, strobes ramp 1,2,3,...; tx_ready=1 -> bytes A5,00,04,00,05,00,06,00,07; done once.
REQ-038 decim=2, ramp from 1 -> stored words 4,7,10,13 (after 3 flushed strobes).
REQ-039 tx_ready toggled randomly -> same byte sequence, tx_data stable throughout every stall.
REQ-040 start pulsed during CAPTURE and SEND_LO -> ignored, byte count exactly 9.
REQ-041 rst_n low mid-SEND_HI -> all outputs 0 next edge; new start yields clean A5-led frame.
REQ-042 adc_vld=1 same cycle as start -> first stored word is the 4th strobe after start, not 3rd.
